wb_commit_stage: RTL and testbench

// Write-back/commit stage of the 5-stage RV32 pipeline: the writer side of the

---
 rtl/wb_commit_stage.sv | 151 +++++++++++++++
 tb/tb_wb_commit_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - RV32 write-back/commit stage driving the decode register/CSR write port
module wb_commit_stage #(
    parameter int                  DBITS      = 32,
    parameter int                  REGNOBITS  = 5,
    parameter int                  CSRNOBITS  = 4,
    parameter int                  ICBITS     = 32,
    parameter int                  CANARYBITS = 32,
    parameter logic [CANARYBITS-1:0] CANARY_VAL = 32'hC0FFEE00,
    parameter logic [CSRNOBITS-1:0]  HALT_CSR   = 4'd15
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   mem_valid,
    input  logic                                   mem_wr_reg,
    input  logic [REGNOBITS-1:0]                   mem_wregno,
    input  logic                                   mem_wr_csr,
    input  logic [CSRNOBITS-1:0]                   mem_wcsrno,
    input  logic [DBITS-1:0]                       mem_regval,
    input  logic [DBITS-1:0]                       mem_csrval,
    input  logic [ICBITS-1:0]                      mem_inst_cnt,
    input  logic [CANARYBITS-1:0]                  mem_canary,
    output logic                                   wb_stall,
    output logic [REGNOBITS+DBITS+CSRNOBITS+1:0]   from_WB_to_DE,
    output logic [ICBITS-1:0]                      retire_count,
    output logic                                   halted,
    output logic                                   order_err,
    output logic                                   canary_err
);
    typedef enum logic [1:0] {RUN, SPLIT, HALTED} state_t;

    state_t                 state_q, state_d;
    logic                   wr_reg_q, wr_reg_d;
    logic                   wr_csr_q, wr_csr_d;
    logic [REGNOBITS-1:0]   wregno_q, wregno_d;
    logic [DBITS-1:0]       regval_q, regval_d;
    logic [CSRNOBITS-1:0]   wcsrno_q, wcsrno_d;
    logic [CSRNOBITS-1:0]   pend_csrno_q, pend_csrno_d;
    logic [DBITS-1:0]       pend_csrval_q, pend_csrval_d;
    logic [ICBITS-1:0]      retire_q, retire_d;
    logic [ICBITS-1:0]      expect_q, expect_d;
    logic                   halted_q, halted_d;
    logic                   order_err_q, order_err_d;
    logic                   canary_err_q, canary_err_d;
    logic                   stall_q, stall_d;

    logic accept;
    logic eff_wr_reg;

    assign accept     = mem_valid & ~stall_q;
    // x0 is hardwired zero, so a write to it is not a real GPR write
    assign eff_wr_reg = mem_wr_reg & (mem_wregno != '0);

    always_comb begin
        state_d       = state_q;
        wr_reg_d      = 1'b0;
        wr_csr_d      = 1'b0;
        wregno_d      = wregno_q;
        regval_d      = regval_q;
        wcsrno_d      = wcsrno_q;
        pend_csrno_d  = pend_csrno_q;
        pend_csrval_d = pend_csrval_q;
        retire_d      = retire_q;
        expect_d      = expect_q;
        order_err_d   = order_err_q;
        canary_err_d  = canary_err_q;
        halted_d      = (state_q == HALTED);

        case (state_q)
            RUN: begin
                if (accept) begin
                    retire_d = retire_q + 1'b1;
                    expect_d = mem_inst_cnt + 1'b1;
                    if (mem_inst_cnt != expect_q)
                        order_err_d = 1'b1;
                    if (mem_canary != CANARY_VAL)
                        canary_err_d = 1'b1;
                    if (eff_wr_reg) begin
                        wr_reg_d = 1'b1;
                        wregno_d = mem_wregno;
                        regval_d = mem_regval;
                        // decode's port favours the GPR, so the CSR half goes out next cycle
                        if (mem_wr_csr) begin
                            pend_csrno_d  = mem_wcsrno;
                            pend_csrval_d = mem_csrval;
                            state_d       = SPLIT;
                        end
                    end else if (mem_wr_csr) begin
                        wr_csr_d = 1'b1;
                        wcsrno_d = mem_wcsrno;
                        regval_d = mem_csrval;
                        if (mem_wcsrno == HALT_CSR && mem_csrval[0])
                            state_d = HALTED;
                    end
                end
            end
            SPLIT: begin
                wr_csr_d = 1'b1;
                wcsrno_d = pend_csrno_q;
                regval_d = pend_csrval_q;
                if (pend_csrno_q == HALT_CSR && pend_csrval_q[0])
                    state_d = HALTED;
                else
                    state_d = RUN;
            end
            default: ;
        endcase

        stall_d = (state_d != RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wr_reg_q      <= 1'b0;
            wr_csr_q      <= 1'b0;
            wregno_q      <= '0;
            regval_q      <= '0;
            wcsrno_q      <= '0;
            pend_csrno_q  <= '0;
            pend_csrval_q <= '0;
            retire_q      <= '0;
            expect_q      <= '0;
            halted_q      <= 1'b0;
            order_err_q   <= 1'b0;
            canary_err_q  <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_reg_q      <= wr_reg_d;
            wr_csr_q      <= wr_csr_d;
            wregno_q      <= wregno_d;
            regval_q      <= regval_d;
            wcsrno_q      <= wcsrno_d;
            pend_csrno_q  <= pend_csrno_d;
            pend_csrval_q <= pend_csrval_d;
            retire_q      <= retire_d;
            expect_q      <= expect_d;
            halted_q      <= halted_d;
            order_err_q   <= order_err_d;
            canary_err_q  <= canary_err_d;
            stall_q       <= stall_d;
        end
    end

    assign wb_stall      = stall_q;
    assign from_WB_to_DE = {wr_reg_q, wregno_q, regval_q, wcsrno_q, wr_csr_q};
    assign retire_count  = retire_q;
    assign halted        = halted_q;
    assign order_err     = order_err_q;
    assign canary_err    = canary_err_q;
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed self-checking bench for wb_commit_stage
module tb_wb_commit_stage;
    localparam logic [31:0] GOOD = 32'hC0FFEE00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_wr_reg = 1'b0;
    logic [4:0]  mem_wregno = '0;
    logic        mem_wr_csr = 1'b0;
    logic [3:0]  mem_wcsrno = '0;
    logic [31:0] mem_regval = '0;
    logic [31:0] mem_csrval = '0;
    logic [31:0] mem_inst_cnt = '0;
    logic [31:0] mem_canary = GOOD;
    logic        wb_stall;
    logic [42:0] bus;
    logic [31:0] retire_count;
    logic        halted, order_err, canary_err;

    int passes = 0;
    int total  = 0;

    wb_commit_stage dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_wr_reg(mem_wr_reg),
        .mem_wregno(mem_wregno), .mem_wr_csr(mem_wr_csr), .mem_wcsrno(mem_wcsrno),
        .mem_regval(mem_regval), .mem_csrval(mem_csrval), .mem_inst_cnt(mem_inst_cnt),
        .mem_canary(mem_canary), .wb_stall(wb_stall), .from_WB_to_DE(bus),
        .retire_count(retire_count), .halted(halted), .order_err(order_err),
        .canary_err(canary_err)
    );

    always #5 clk = ~clk;

    wire        o_wr_reg = bus[42];
    wire [4:0]  o_wregno = bus[41:37];
    wire [31:0] o_regval = bus[36:5];
    wire [3:0]  o_wcsrno = bus[4:1];
    wire        o_wr_csr = bus[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic [4:0] rn, input logic [31:0] rv,
                         input logic wc, input logic [3:0] cn, input logic [31:0] cv,
                         input logic [31:0] cnt, input logic [31:0] can);
        mem_valid = v; mem_wr_reg = wr; mem_wregno = rn; mem_regval = rv;
        mem_wr_csr = wc; mem_wcsrno = cn; mem_csrval = cv; mem_inst_cnt = cnt; mem_canary = can;
    endtask

    initial begin
        #12;
        chk("rst_bus", {21'd0, bus[10:0]}, 32'd0);
        chk("rst_bus_hi", bus[42:11], 32'd0);
        chk("rst_retire", retire_count, 0);
        chk("rst_flags", {wb_stall, halted, order_err, canary_err}, 0);
        reset = 1'b0;

        // single GPR write x5=0x1234
        drive(1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, GOOD);
        step();
        chk("add_wr_reg", o_wr_reg, 1);
        chk("add_wregno", o_wregno, 5);
        chk("add_regval", o_regval, 32'h1234);
        chk("add_retire", retire_count, 1);
        chk("add_stall", wb_stall, 0);

        // x0 write is suppressed, still retires
        drive(1, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, GOOD);
        step();
        chk("x0_wr_reg", o_wr_reg, 0);
        chk("x0_regval_hold", o_regval, 32'h1234);
        chk("x0_retire", retire_count, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, GOOD);
        step();
        chk("idle_en", {o_wr_reg, o_wr_csr}, 0);

        // dual write: GPR first, CSR the following cycle
        drive(1, 1, 5'd3, 32'hA, 1, 4'd2, 32'hB, 2, GOOD);
        step();
        chk("dual1_en", {o_wr_reg, o_wr_csr}, 2'b10);
        chk("dual1_wregno", o_wregno, 3);
        chk("dual1_regval", o_regval, 32'hA);
        chk("dual1_stall", wb_stall, 1);
        chk("dual1_retire", retire_count, 3);
        drive(1, 1, 5'd7, 32'h77, 0, 0, 0, 3, GOOD);
        step();
        chk("dual2_en", {o_wr_reg, o_wr_csr}, 2'b01);
        chk("dual2_wcsrno", o_wcsrno, 2);
        chk("dual2_regval", o_regval, 32'hB);
        chk("dual2_stall", wb_stall, 0);
        chk("dual2_retire_held", retire_count, 3);
        step();
        chk("next_en", {o_wr_reg, o_wr_csr}, 2'b10);
        chk("next_wregno", o_wregno, 7);
        chk("next_retire", retire_count, 4);

        // order check: 4 in order, 6 skips, 7 resynced
        drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 4, GOOD);
        step();
        chk("ord4", order_err, 0);
        mem_inst_cnt = 6;
        step();
        chk("ord6", order_err, 1);
        mem_inst_cnt = 7;
        step();
        chk("ord7_sticky", order_err, 1);
        chk("ord_retire", retire_count, 7);

        // bad canary still commits
        drive(1, 1, 5'd9, 32'h99, 0, 0, 0, 8, 32'h0);
        step();
        chk("can_err", canary_err, 1);
        chk("can_wr_reg", o_wr_reg, 1);
        chk("can_regval", o_regval, 32'h99);
        chk("can_retire", retire_count, 8);

        // halt CSR with bit0=0 does not halt
        drive(1, 0, 0, 0, 1, 4'd15, 32'h2, 9, GOOD);
        step();
        chk("csr15_even_en", {o_wr_reg, o_wr_csr}, 2'b01);
        chk("csr15_even_stall", wb_stall, 0);
        step();
        chk("csr15_even_halted", halted, 0);

        // reset mid-SPLIT drops the pending CSR write
        drive(1, 1, 5'd1, 32'h1, 1, 4'd3, 32'h33, 11, GOOD);
        step();
        chk("split_stall", wb_stall, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, GOOD);
        reset = 1'b1;
        #1;
        chk("arst_bus", bus[31:0], 0);
        chk("arst_retire", retire_count, 0);
        chk("arst_flags", {wb_stall, halted, order_err, canary_err}, 0);
        step();
        reset = 1'b0;
        step();
        chk("arst_no_csr", {o_wr_reg, o_wr_csr}, 0);
        chk("arst_stall", wb_stall, 0);

        // halt via dual write: CSR 15 = 3 emitted in split cycle
        drive(1, 1, 5'd2, 32'h5, 1, 4'd15, 32'h3, 0, GOOD);
        step();
        chk("hs_gpr", {o_wr_reg, o_wr_csr}, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0, 0, GOOD);
        step();
        chk("hs_csr_en", {o_wr_reg, o_wr_csr}, 2'b01);
        chk("hs_csr_val", o_regval, 32'h3);
        chk("hs_stall", wb_stall, 1);
        chk("hs_halted_pre", halted, 0);
        step();
        chk("hs_halted", halted, 1);

        // halt via single CSR write 15 = 1
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, 0, 0, 0, 1, 4'd15, 32'h1, 0, GOOD);
        step();
        chk("h_en", {o_wr_reg, o_wr_csr}, 2'b01);
        chk("h_wcsrno", o_wcsrno, 15);
        chk("h_stall", wb_stall, 1);
        chk("h_halted_pre", halted, 0);
        chk("h_retire", retire_count, 1);
        drive(1, 1, 5'd4, 32'h44, 0, 0, 0, 1, GOOD);
        step();
        chk("h_halted", halted, 1);
        chk("h_frozen_en", {o_wr_reg, o_wr_csr}, 0);
        step();
        step();
        chk("h_retire_frozen", retire_count, 1);
        chk("h_stall_hold", wb_stall, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
